// File: rtl/shift_reg_ctrl.sv
// shift_reg_ctrl: command sequencer for a 4-bit universal shift register.
// It accepts LOAD/SHR/SHL/ROTR commands and drives the register mode, data and serial input.
// It reports BUSY while a command runs and pulses DONE for one cycle when a command completes.
module shift_reg_ctrl #(
    parameter int unsigned CNT_W = 3
) (
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [1:0]       i_cmd_op,
    input  logic [CNT_W-1:0] i_cmd_cnt,
    input  logic [3:0]       i_cmd_data,
    input  logic             i_ser_in,
    input  logic             i_abort,
    input  logic [3:0]       i_sr_q,
    output logic [1:0]       o_sr_s,
    output logic [3:0]       o_sr_d,
    output logic             o_sr_ser,
    output logic             o_busy,
    output logic             o_done
);

    localparam logic [1:0] OP_LOAD   = 2'b00;
    localparam logic [1:0] OP_SHR    = 2'b01;
    localparam logic [1:0] OP_SHL    = 2'b10;
    localparam logic [1:0] OP_ROTR   = 2'b11;

    localparam logic [1:0] MODE_LOAD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_HOLD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIN  = 2'b10
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_op;
    logic [3:0]       r_data;
    logic             r_cmd_ready;
    logic [1:0]       r_sr_s;
    logic [3:0]       r_sr_d;
    logic             r_busy;
    logic             r_done;
    logic             w_sr_ser;
    logic             w_unused_q;

    // Controller FSM; the output registers are loaded with the values that belong to the next state.
    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_op        <= '0;
            r_data      <= '0;
            r_cmd_ready <= 1'b1;
            r_sr_s      <= MODE_HOLD;
            r_sr_d      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_cmd_valid) begin
                        r_op        <= i_cmd_op;
                        r_data      <= i_cmd_data;
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (i_cmd_op == OP_LOAD) begin
                            // A LOAD always runs for exactly one cycle.
                            r_cnt   <= CNT_W'(1);
                            r_state <= ST_RUN;
                            r_sr_s  <= MODE_LOAD;
                            r_sr_d  <= i_cmd_data;
                        end else if (i_cmd_cnt != '0) begin
                            r_cnt   <= i_cmd_cnt;
                            r_state <= ST_RUN;
                            // Rotate uses the shift-right path, with Q[0] fed back as the serial bit.
                            r_sr_s  <= (i_cmd_op == OP_ROTR) ? MODE_SHR : i_cmd_op;
                        end else begin
                            // A zero-length shift completes without touching the register.
                            r_cnt   <= '0;
                            r_state <= ST_FIN;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (i_abort) begin
                        r_cnt       <= '0;
                        r_state     <= ST_IDLE;
                        r_cmd_ready <= 1'b1;
                        r_sr_s      <= MODE_HOLD;
                        r_sr_d      <= '0;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (r_cnt == CNT_W'(1)) begin
                            r_state <= ST_FIN;
                            r_sr_s  <= MODE_HOLD;
                            r_sr_d  <= '0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_FIN: begin
                    r_state     <= ST_IDLE;
                    r_cmd_ready <= 1'b1;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b0;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_cnt       <= '0;
                    r_cmd_ready <= 1'b1;
                    r_sr_s      <= MODE_HOLD;
                    r_sr_d      <= '0;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b0;
                end
            endcase
        end
    end

    // Serial bit passes straight through while shifting: live SER_IN, or Q[0] for a rotate.
    always_comb begin
        w_sr_ser = 1'b0;
        if (r_state == ST_RUN) begin
            case (r_op)
                OP_SHR, OP_SHL: w_sr_ser = i_ser_in;
                OP_ROTR:        w_sr_ser = i_sr_q[0];
                default:        w_sr_ser = 1'b0;
            endcase
        end
    end

    // Only Q[0] is needed, for the rotate feedback.
    assign w_unused_q  = ^i_sr_q[3:1];

    assign o_cmd_ready = r_cmd_ready;
    assign o_sr_s      = r_sr_s;
    assign o_sr_d      = r_sr_d;
    assign o_sr_ser    = w_sr_ser;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Testbench for shift_reg_ctrl: directed commands against a behavioural 4-bit shift register.
module tb_shift_reg_ctrl;

    localparam int unsigned CNT_W = 3;

    // Observation vector layout: {ready, busy, done, sr_s[1:0], sr_d[3:0], ser}
    localparam logic [9:0] OBS_IDLE = 10'b1_0_0_11_0000_0;
    localparam logic [9:0] OBS_FIN  = 10'b0_1_1_11_0000_0;

    logic             clk = 1'b0;
    logic             clr;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_cnt;
    logic [3:0]       cmd_data;
    logic             ser_in;
    logic             abort;
    logic [3:0]       q;
    logic [1:0]       sr_s;
    logic [3:0]       sr_d;
    logic             sr_ser;
    logic             busy;
    logic             done;
    logic [9:0]       obs;

    int n_tests = 0;
    int n_fail  = 0;

    shift_reg_ctrl #(.CNT_W(CNT_W)) dut (
        .i_clk       (clk),
        .i_clr       (clr),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .i_cmd_op    (cmd_op),
        .i_cmd_cnt   (cmd_cnt),
        .i_cmd_data  (cmd_data),
        .i_ser_in    (ser_in),
        .i_abort     (abort),
        .i_sr_q      (q),
        .o_sr_s      (sr_s),
        .o_sr_d      (sr_d),
        .o_sr_ser    (sr_ser),
        .o_busy      (busy),
        .o_done      (done)
    );

    always #5 clk = ~clk;

    assign obs = {cmd_ready, busy, done, sr_s, sr_d, sr_ser};

    // Behavioural universal shift register driven by the controller.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) q <= 4'b0000;
        else begin
            case (sr_s)
                2'b00:   q <= sr_d;
                2'b01:   q <= {sr_ser, q[3:1]};
                2'b10:   q <= {q[2:0], sr_ser};
                default: q <= q;
            endcase
        end
    end

    function automatic logic [9:0] run_obs(input logic [1:0] s, input logic [3:0] d, input logic ser);
        return {1'b0, 1'b1, 1'b0, s, d, ser};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [CNT_W-1:0] cnt, input logic [3:0] data);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_cnt   = cnt;
        cmd_data  = data;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Puts a known value into the register; the full LOAD sequence is checked in test_load.
    task automatic preset_q(input logic [3:0] data);
        send(2'b00, '0, data);
        tick();
        tick();
    endtask

    task automatic test_reset();
        clr = 1'b1;
        #1;
        n_tests++;
        if (obs !== OBS_IDLE) begin n_fail++; $display("FAIL reset_async: got %b expected %b", obs, OBS_IDLE); end
        tick();
        n_tests++;
        if (obs !== OBS_IDLE) begin n_fail++; $display("FAIL reset_held: got %b expected %b", obs, OBS_IDLE); end
        @(negedge clk);
        clr = 1'b0;
        tick();
        n_tests++;
        if (obs !== OBS_IDLE) begin n_fail++; $display("FAIL reset_release: got %b expected %b", obs, OBS_IDLE); end
    endtask

    task automatic test_load();
        send(2'b00, '0, 4'b1010);
        n_tests++;
        if (obs !== run_obs(2'b00, 4'b1010, 1'b0)) begin n_fail++; $display("FAIL load_run: got %b expected %b", obs, run_obs(2'b00, 4'b1010, 1'b0)); end
        tick();
        n_tests++;
        if (obs !== OBS_FIN) begin n_fail++; $display("FAIL load_done: got %b expected %b", obs, OBS_FIN); end
        n_tests++;
        if (q !== 4'b1010) begin n_fail++; $display("FAIL load_q: got %b expected 1010", q); end
        tick();
        n_tests++;
        if (obs !== OBS_IDLE) begin n_fail++; $display("FAIL load_ready: got %b expected %b", obs, OBS_IDLE); end
    endtask

    task automatic test_rotr();
        logic [3:0] exp_q [2]   = '{4'b1100, 4'b0110};
        logic       exp_ser [2] = '{1'b1, 1'b0};
        preset_q(4'b1001);
        send(2'b11, 3'd2, 4'b0000);
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (obs !== run_obs(2'b01, 4'b0000, exp_ser[i])) begin n_fail++; $display("FAIL rotr_run%0d: got %b expected %b", i, obs, run_obs(2'b01, 4'b0000, exp_ser[i])); end
            tick();
            n_tests++;
            if (q !== exp_q[i]) begin n_fail++; $display("FAIL rotr_q%0d: got %b expected %b", i, q, exp_q[i]); end
        end
        n_tests++;
        if (obs !== OBS_FIN) begin n_fail++; $display("FAIL rotr_done: got %b expected %b", obs, OBS_FIN); end
        tick();
        n_tests++;
        if (obs !== OBS_IDLE) begin n_fail++; $display("FAIL rotr_idle: got %b expected %b", obs, OBS_IDLE); end
    endtask

    task automatic test_shl();
        logic [3:0] exp_q [3] = '{4'b0001, 4'b0011, 4'b0111};
        preset_q(4'b0000);
        ser_in = 1'b1;
        send(2'b10, 3'd3, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (obs !== run_obs(2'b10, 4'b0000, 1'b1)) begin n_fail++; $display("FAIL shl_run%0d: got %b expected %b", i, obs, run_obs(2'b10, 4'b0000, 1'b1)); end
            tick();
            n_tests++;
            if (q !== exp_q[i]) begin n_fail++; $display("FAIL shl_q%0d: got %b expected %b", i, q, exp_q[i]); end
        end
        n_tests++;
        if (obs !== OBS_FIN) begin n_fail++; $display("FAIL shl_done: got %b expected %b", obs, OBS_FIN); end
        tick();
        tick();
        n_tests++;
        if (obs !== OBS_IDLE) begin n_fail++; $display("FAIL shl_idle: got %b expected %b", obs, OBS_IDLE); end
        n_tests++;
        if (q !== 4'b0111) begin n_fail++; $display("FAIL shl_hold: got %b expected 0111", q); end
        ser_in = 1'b0;
    endtask

    task automatic test_abort();
        preset_q(4'b1111);
        send(2'b01, 3'd5, 4'b0000);
        n_tests++;
        if (obs !== run_obs(2'b01, 4'b0000, 1'b0)) begin n_fail++; $display("FAIL abort_run1: got %b expected %b", obs, run_obs(2'b01, 4'b0000, 1'b0)); end
        tick();
        n_tests++;
        if (obs !== run_obs(2'b01, 4'b0000, 1'b0)) begin n_fail++; $display("FAIL abort_run2: got %b expected %b", obs, run_obs(2'b01, 4'b0000, 1'b0)); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_tests++;
        if (obs !== OBS_IDLE) begin n_fail++; $display("FAIL abort_idle: got %b expected %b", obs, OBS_IDLE); end
        n_tests++;
        if (q !== 4'b0011) begin n_fail++; $display("FAIL abort_q: got %b expected 0011", q); end
        tick();
        n_tests++;
        if (obs !== OBS_IDLE || q !== 4'b0011) begin n_fail++; $display("FAIL abort_after: got %b q %b expected %b q 0011", obs, q, OBS_IDLE); end
    endtask

    task automatic test_cnt0();
        ser_in = 1'b1;
        send(2'b01, 3'd0, 4'b0000);
        n_tests++;
        if (obs !== OBS_FIN) begin n_fail++; $display("FAIL cnt0_done: got %b expected %b", obs, OBS_FIN); end
        tick();
        n_tests++;
        if (obs !== OBS_IDLE || q !== 4'b0011) begin n_fail++; $display("FAIL cnt0_idle: got %b q %b expected %b q 0011", obs, q, OBS_IDLE); end
        ser_in = 1'b0;
    endtask

    task automatic test_abort_accept();
        abort = 1'b1;
        send(2'b00, '0, 4'b0101);
        abort = 1'b0;
        n_tests++;
        if (obs !== run_obs(2'b00, 4'b0101, 1'b0)) begin n_fail++; $display("FAIL abort_accept_run: got %b expected %b", obs, run_obs(2'b00, 4'b0101, 1'b0)); end
        tick();
        n_tests++;
        if (obs !== OBS_FIN || q !== 4'b0101) begin n_fail++; $display("FAIL abort_accept_done: got %b q %b expected %b q 0101", obs, q, OBS_FIN); end
        tick();
    endtask

    task automatic test_back_to_back();
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_cnt   = '0;
        cmd_data  = 4'b0011;
        tick();
        n_tests++;
        if (obs !== run_obs(2'b00, 4'b0011, 1'b0)) begin n_fail++; $display("FAIL b2b_run1: got %b expected %b", obs, run_obs(2'b00, 4'b0011, 1'b0)); end
        cmd_data = 4'b1100;
        tick();
        n_tests++;
        if (obs !== OBS_FIN || q !== 4'b0011) begin n_fail++; $display("FAIL b2b_fin1: got %b q %b expected %b q 0011", obs, q, OBS_FIN); end
        tick();
        n_tests++;
        if (obs !== OBS_IDLE) begin n_fail++; $display("FAIL b2b_gap: got %b expected %b", obs, OBS_IDLE); end
        tick();
        cmd_valid = 1'b0;
        n_tests++;
        if (obs !== run_obs(2'b00, 4'b1100, 1'b0)) begin n_fail++; $display("FAIL b2b_run2: got %b expected %b", obs, run_obs(2'b00, 4'b1100, 1'b0)); end
        tick();
        n_tests++;
        if (obs !== OBS_FIN || q !== 4'b1100) begin n_fail++; $display("FAIL b2b_fin2: got %b q %b expected %b q 1100", obs, q, OBS_FIN); end
        tick();
    endtask

    task automatic test_clr_mid();
        ser_in = 1'b1;
        send(2'b10, 3'd7, 4'b0000);
        n_tests++;
        if (obs !== run_obs(2'b10, 4'b0000, 1'b1)) begin n_fail++; $display("FAIL clr_mid_run: got %b expected %b", obs, run_obs(2'b10, 4'b0000, 1'b1)); end
        tick();
        #2;
        clr = 1'b1;
        #1;
        n_tests++;
        if (obs !== OBS_IDLE) begin n_fail++; $display("FAIL clr_mid_async: got %b expected %b", obs, OBS_IDLE); end
        tick();
        n_tests++;
        if (obs !== OBS_IDLE) begin n_fail++; $display("FAIL clr_mid_nodone: got %b expected %b", obs, OBS_IDLE); end
        ser_in = 1'b0;
        @(negedge clk);
        clr       = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_cnt   = '0;
        cmd_data  = 4'b0110;
        tick();
        cmd_valid = 1'b0;
        n_tests++;
        if (obs !== run_obs(2'b00, 4'b0110, 1'b0)) begin n_fail++; $display("FAIL clr_mid_accept: got %b expected %b", obs, run_obs(2'b00, 4'b0110, 1'b0)); end
        tick();
        n_tests++;
        if (obs !== OBS_FIN || q !== 4'b0110) begin n_fail++; $display("FAIL clr_mid_done: got %b q %b expected %b q 0110", obs, q, OBS_FIN); end
        tick();
    endtask

    initial begin
        clr       = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_cnt   = '0;
        cmd_data  = 4'b0000;
        ser_in    = 1'b0;
        abort     = 1'b0;
        #2;
        test_reset();
        test_load();
        test_rotr();
        test_shl();
        test_abort();
        test_cnt0();
        test_abort_accept();
        test_back_to_back();
        test_clr_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
